decode_stage_reg: RTL and testbench

Registered, handshaked instruction-decode stage for the pipelined CPU: splits each 32-bit MIPS instruction into its fields, classifies its format, extends the immediate and forms the jump target. It sits between fetch and register-read/execute. It replaces the combinational field splitter used in the single-cycle core with a two-entry skid buffer, valid/ready flow control and flush. Output width and PC width are parametrised.

---
 rtl/cpu_decode_pkg.sv | 39 +++
 rtl/inst_field_decode.sv | 41 ++++
 rtl/decode_stage_reg.sv | 98 +++++++++
 tb/tb_decode_stage_reg.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_decode_pkg.sv
// Shared opcode constants, instruction format enum and raw field layout for the decode stage.
package cpu_decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_e;

    // Width-independent part of a decoded instruction; the XLEN/PC_W-sized
    // fields are appended by the modules that know those widths.
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
        fmt_e       fmt;
    } inst_fields_t;

    function automatic fmt_e classify(input logic [5:0] op);
        if (op == OP_RTYPE)
            return FMT_R;
        else if (op == OP_J || op == OP_JAL)
            return FMT_J;
        else
            return FMT_I;
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational MIPS field splitter: raw fields, format, extended immediate and jump target.
module inst_field_decode
    import cpu_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic [31:0]     inst,
    input  logic [PC_W-1:0] pc,
    output inst_fields_t    fields,
    output logic [XLEN-1:0] imm,
    output logic [PC_W-1:0] jtarget
);

    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] upper_mask;

    always_comb begin
        fields.op    = inst[31:26];
        fields.rs    = inst[25:21];
        fields.rt    = inst[20:16];
        fields.rd    = inst[15:11];
        fields.shamt = inst[10:6];
        fields.funct = inst[5:0];
        fields.fmt   = classify(inst[31:26]);
    end

    always_comb begin
        case (inst[31:26])
            OP_ANDI, OP_ORI, OP_XORI: imm = XLEN'(inst[15:0]);
            OP_LUI:                   imm = XLEN'($signed({inst[15:0], 16'h0000}));
            default:                  imm = XLEN'($signed(inst[15:0]));
        endcase
    end

    // Region bits above 28 come from pc+4; the mask is empty when PC_W == 28.
    assign pc4        = pc + PC_W'(4);
    assign upper_mask = {PC_W{1'b1}} << 28;
    assign jtarget    = (pc4 & upper_mask) | PC_W'({inst[25:0], 2'b00});

endmodule

// File: rtl/decode_stage_reg.sv
// Registered decode stage: input-side decode feeding a two-entry skid buffer with flush.
module decode_stage_reg
    import cpu_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_op,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_funct,
    output logic [XLEN-1:0] out_imm,
    output logic [PC_W-1:0] out_jtarget,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      out_fmt
);

    typedef struct packed {
        inst_fields_t    f;
        logic [XLEN-1:0] imm;
        logic [PC_W-1:0] jtarget;
        logic [PC_W-1:0] pc;
    } decoded_t;

    decoded_t     dec, main_q, skid_q;
    logic         main_valid, skid_valid;
    logic         in_fire, out_fire;
    inst_fields_t dec_fields;
    logic [XLEN-1:0] dec_imm;
    logic [PC_W-1:0] dec_jtarget;

    inst_field_decode #(.XLEN(XLEN), .PC_W(PC_W)) u_decode (
        .inst    (in_inst),
        .pc      (in_pc),
        .fields  (dec_fields),
        .imm     (dec_imm),
        .jtarget (dec_jtarget)
    );

    assign dec = '{f: dec_fields, imm: dec_imm, jtarget: dec_jtarget, pc: in_pc};

    // Ready depends only on registered state so it never loops through out_ready.
    assign in_ready = !skid_valid && rst_n;
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_fire) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= in_fire;
                if (in_fire)
                    skid_q <= dec;
            end else if (in_fire) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_op      = main_q.f.op;
    assign out_rs      = main_q.f.rs;
    assign out_rt      = main_q.f.rt;
    assign out_rd      = main_q.f.rd;
    assign out_shamt   = main_q.f.shamt;
    assign out_funct   = main_q.f.funct;
    assign out_fmt     = main_q.f.fmt;
    assign out_imm     = main_q.imm;
    assign out_jtarget = main_q.jtarget;
    assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_decode_stage_reg.sv
// Directed bench for decode_stage_reg: decode fields, immediates, jumps, skid backpressure, flush, reset.
module tb_decode_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic [5:0]  out_op, out_funct;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [31:0] out_imm, out_jtarget, out_pc;
    logic [1:0]  out_fmt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage_reg #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm),
        .out_jtarget(out_jtarget), .out_pc(out_pc), .out_fmt(out_fmt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single edge, then idle the input.
    task automatic send_one(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h012A4020; in_pc = 32'h0040_0000;
        step(); step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests++; if ({out_op, out_rs, out_rt, out_rd, out_shamt, out_funct, out_fmt} !== 34'd0 ||
                     out_imm !== 32'd0 || out_jtarget !== 32'd0 || out_pc !== 32'd0) begin
            fails++; $display("FAIL reset_data got imm %h jt %h pc %h rd %0d want all zero", out_imm, out_jtarget, out_pc, out_rd);
        end
        in_valid = 1'b0; rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %b want 1", in_ready); end
        step();
    endtask

    task automatic test_rtype();
        send_one(32'h012A4020, 32'h0040_0000);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rtype_valid got %b want 1", out_valid); end
        tests++; if (out_fmt !== 2'd0 || out_op !== 6'd0) begin fails++; $display("FAIL rtype_fmt got fmt %0d op %h want 0/0", out_fmt, out_op); end
        tests++; if (out_rs !== 5'd9 || out_rt !== 5'd10 || out_rd !== 5'd8) begin
            fails++; $display("FAIL rtype_regs got rs %0d rt %0d rd %0d want 9 10 8", out_rs, out_rt, out_rd);
        end
        tests++; if (out_funct !== 6'h20 || out_shamt !== 5'd0) begin fails++; $display("FAIL rtype_funct got %h/%0d want 20/0", out_funct, out_shamt); end
        tests++; if (out_pc !== 32'h0040_0000) begin fails++; $display("FAIL rtype_pc got %h want 00400000", out_pc); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rtype_drain got %b want 0", out_valid); end
    endtask

    task automatic test_imm();
        logic [31:0] insts [5];
        logic [31:0] imms  [5];
        insts = '{32'h2108FFFF, 32'h3508FFFF, 32'h3C081234, 32'h3108_8001, 32'h3C08_8000};
        imms  = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h1234_0000, 32'h0000_8001, 32'h8000_0000};
        for (int i = 0; i < 5; i++) begin
            send_one(insts[i], 32'h0040_0100);
            tests++; if (out_valid !== 1'b1 || out_imm !== imms[i] || out_fmt !== 2'd1) begin
                fails++; $display("FAIL imm_%0d got v %b imm %h fmt %0d want 1 %h 1", i, out_valid, out_imm, out_fmt, imms[i]);
            end
        end
        step();
    endtask

    task automatic test_jump();
        logic [31:0] insts [4];
        logic [31:0] pcs   [4];
        logic [31:0] tgts  [4];
        insts = '{32'h08100004, 32'h0BFF_FFFF, 32'h0C00_0001, 32'h0800_0003};
        pcs   = '{32'h1000_0000, 32'hFFFF_FFFC, 32'hF000_0000, 32'h2FFF_FFFC};
        tgts  = '{32'h1040_0010, 32'h0FFF_FFFC, 32'hF000_0004, 32'h3000_000C};
        for (int i = 0; i < 4; i++) begin
            send_one(insts[i], pcs[i]);
            tests++; if (out_valid !== 1'b1 || out_fmt !== 2'd2 || out_jtarget !== tgts[i]) begin
                fails++; $display("FAIL jump_%0d got v %b fmt %0d jt %h want 1 2 %h", i, out_valid, out_fmt, out_jtarget, tgts[i]);
            end
        end
        step();
    endtask

    // Four R-type instructions tagged by rd = 1..4.
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0000_0820; in_pc = 32'h0000_0100;
        step();
        tests++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_first got v %b rd %0d rdy %b want 1 1 1", out_valid, out_rd, in_ready);
        end
        in_inst = 32'h0000_1020; in_pc = 32'h0000_0104;
        step();
        tests++; if (in_ready !== 1'b0 || out_rd !== 5'd1 || out_pc !== 32'h0000_0100) begin
            fails++; $display("FAIL bp_full got rdy %b rd %0d pc %h want 0 1 00000100", in_ready, out_rd, out_pc);
        end
        in_inst = 32'h0000_1820; in_pc = 32'h0000_0108;
        step();
        tests++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_pc !== 32'h0000_0100 || in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_stable got v %b rd %0d pc %h rdy %b want 1 1 00000100 0", out_valid, out_rd, out_pc, in_ready);
        end
        out_ready = 1'b1;
        step();
        tests++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_second got v %b rd %0d rdy %b want 1 2 1", out_valid, out_rd, in_ready);
        end
        step();
        tests++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_pc !== 32'h0000_0108) begin
            fails++; $display("FAIL bp_third got v %b rd %0d pc %h want 1 3 00000108", out_valid, out_rd, out_pc);
        end
        in_inst = 32'h0000_2020; in_pc = 32'h0000_010C;
        step();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_rd !== 5'd4) begin
            fails++; $display("FAIL bp_fourth got v %b rd %0d want 1 4", out_valid, out_rd);
        end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_inst = {16'h0, 5'(i + 8), 11'h020};
            in_pc   = 32'h0000_0200 + 32'(4 * i);
            step();
            tests++; if (out_valid !== 1'b1 || out_rd !== 5'(i + 8) || in_ready !== 1'b1) begin
                fails++; $display("FAIL b2b_%0d got v %b rd %0d rdy %b want 1 %0d 1", i, out_valid, out_rd, in_ready, i + 8);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send_one(32'h0000_0820, 32'h0000_0300);
        send_one(32'h0000_1020, 32'h0000_0304);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_F820; in_pc = 32'h0000_0308;
        step();
        flush = 1'b0; in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_state got v %b rdy %b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_dropped got v %b rd %0d want 0", out_valid, out_rd); end
        step();
    endtask

    task automatic test_midreset();
        out_ready = 1'b0;
        send_one(32'h2108_1234, 32'h0000_0400);
        send_one(32'h0810_0004, 32'h1000_0000);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mr_full got rdy %b want 0", in_ready); end
        rst_n = 1'b0; in_valid = 1'b1; in_inst = 32'h0000_0820;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mr_rdy_low got %b want 0", in_ready); end
        step();
        tests++; if (out_valid !== 1'b0 || out_imm !== 32'd0 || out_jtarget !== 32'd0 || out_pc !== 32'd0 ||
                     {out_op, out_rs, out_rt, out_rd, out_shamt, out_funct, out_fmt} !== 34'd0) begin
            fails++; $display("FAIL mr_clear got v %b imm %h jt %h pc %h want 0 and zero data", out_valid, out_imm, out_jtarget, out_pc);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL mr_release got rdy %b v %b want 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        test_reset();
        test_rtype();
        test_imm();
        test_jump();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
